// File: rtl/conv_load_ctrl.sv
// conv_load_ctrl: byte-serial image/weight loader and convolution core sequencer
// Ports: clk/rst (sync, active-high); host side mode/din/ram_en/keep_wgt;
// buffer side dbuf_we/dbuf_addr, wbuf_we/wbuf_addr, buf_wdata;
// core side core_start, core_done/core_dout; status dout/out_data_flag,
// busy, sticky err_ovf/err_busy.
module conv_load_ctrl #(
    parameter int DW     = 8,
    parameter int IMG_W  = 8,
    parameter int IMG_H  = 8,
    parameter int IN_CH  = 1,
    parameter int K      = 3,
    parameter int KC     = 3,
    parameter int OUT_CH = 2,
    localparam int DATA_N = IMG_W * IMG_H * IN_CH,
    localparam int WGT_N  = K * K * KC * OUT_CH,
    localparam int DAW    = (DATA_N > 1) ? $clog2(DATA_N) : 1,
    localparam int WAW    = (WGT_N > 1) ? $clog2(WGT_N) : 1
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           mode,
    input  logic [DW-1:0]  din,
    input  logic           ram_en,
    input  logic           keep_wgt,
    output logic           dbuf_we,
    output logic [DAW-1:0] dbuf_addr,
    output logic           wbuf_we,
    output logic [WAW-1:0] wbuf_addr,
    output logic [DW-1:0]  buf_wdata,
    output logic           core_start,
    input  logic           core_done,
    input  logic [DW-1:0]  core_dout,
    output logic [DW-1:0]  dout,
    output logic           out_data_flag,
    output logic           busy,
    output logic           err_ovf,
    output logic           err_busy
);
    // counters hold 0..N inclusive, so they are one value wider than the address
    localparam int DCW = $clog2(DATA_N + 1);
    localparam int WCW = $clog2(WGT_N + 1);
    localparam logic [DCW-1:0] D_FULL = DCW'(DATA_N);
    localparam logic [WCW-1:0] W_FULL = WCW'(WGT_N);
    localparam logic [DCW-1:0] D_ONE  = DCW'(1);
    localparam logic [WCW-1:0] W_ONE  = WCW'(1);

    typedef enum logic [1:0] {S_LOAD, S_START, S_WAIT} state_t;

    state_t         state_q, state_d;
    logic [DCW-1:0] d_cnt_q, d_cnt_d;
    logic [WCW-1:0] w_cnt_q, w_cnt_d;
    logic           dbuf_we_q, dbuf_we_d, wbuf_we_q, wbuf_we_d;
    logic [DAW-1:0] dbuf_addr_q, dbuf_addr_d;
    logic [WAW-1:0] wbuf_addr_q, wbuf_addr_d;
    logic [DW-1:0]  wdata_q, wdata_d, dout_q, dout_d;
    logic           flag_q, flag_d, err_ovf_q, err_ovf_d, err_busy_q, err_busy_d;
    logic           d_full, w_full, in_load, d_acc, w_acc, done;

    assign d_full  = d_cnt_q == D_FULL;
    assign w_full  = w_cnt_q == W_FULL;
    assign in_load = state_q == S_LOAD;
    assign d_acc   = in_load && ram_en && !mode && !d_full;
    assign w_acc   = in_load && ram_en && mode && !w_full;
    assign done    = state_q == S_WAIT && core_done;

    always_comb begin
        state_d     = (in_load && d_full && w_full) ? S_START :
                      (state_q == S_START) ? S_WAIT :
                      done ? S_LOAD : state_q;
        d_cnt_d     = done ? '0 : d_acc ? d_cnt_q + D_ONE : d_cnt_q;
        w_cnt_d     = (done && !keep_wgt) ? '0 : w_acc ? w_cnt_q + W_ONE : w_cnt_q;
        dbuf_we_d   = d_acc;
        wbuf_we_d   = w_acc;
        dbuf_addr_d = d_acc ? d_cnt_q[DAW-1:0] : dbuf_addr_q;
        wbuf_addr_d = w_acc ? w_cnt_q[WAW-1:0] : wbuf_addr_q;
        wdata_d     = (d_acc || w_acc) ? din : wdata_q;
        dout_d      = done ? core_dout : dout_q;
        flag_d      = done;
        // a byte for an already full buffer is dropped and flagged
        err_ovf_d   = err_ovf_q | (in_load && ram_en && (mode ? w_full : d_full));
        err_busy_d  = err_busy_q | (!in_load && ram_en);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_LOAD;
            d_cnt_q     <= '0;
            w_cnt_q     <= '0;
            dbuf_we_q   <= 1'b0;
            wbuf_we_q   <= 1'b0;
            dbuf_addr_q <= '0;
            wbuf_addr_q <= '0;
            wdata_q     <= '0;
            dout_q      <= '0;
            flag_q      <= 1'b0;
            err_ovf_q   <= 1'b0;
            err_busy_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            d_cnt_q     <= d_cnt_d;
            w_cnt_q     <= w_cnt_d;
            dbuf_we_q   <= dbuf_we_d;
            wbuf_we_q   <= wbuf_we_d;
            dbuf_addr_q <= dbuf_addr_d;
            wbuf_addr_q <= wbuf_addr_d;
            wdata_q     <= wdata_d;
            dout_q      <= dout_d;
            flag_q      <= flag_d;
            err_ovf_q   <= err_ovf_d;
            err_busy_q  <= err_busy_d;
        end
    end

    assign dbuf_we       = dbuf_we_q;
    assign dbuf_addr     = dbuf_addr_q;
    assign wbuf_we       = wbuf_we_q;
    assign wbuf_addr     = wbuf_addr_q;
    assign buf_wdata     = wdata_q;
    assign core_start    = state_q == S_START;
    assign busy          = !in_load;
    assign dout          = dout_q;
    assign out_data_flag = flag_q;
    assign err_ovf       = err_ovf_q;
    assign err_busy      = err_busy_q;
endmodule

// File: tb/tb_conv_load_ctrl.sv
// tb_conv_load_ctrl: scoreboard bench for conv_load_ctrl (default and small geometry)
module tb_conv_load_ctrl;
    localparam int DN = 64;
    localparam int WN = 54;

    logic       clk = 0, rst = 1, mode = 0, ram_en = 0, keep_wgt = 0, core_done = 0, ram_en_s = 0;
    logic [7:0] din = 0, core_dout = 0;
    logic       dbuf_we, wbuf_we, core_start, out_data_flag, busy, err_ovf, err_busy;
    logic [5:0] dbuf_addr, wbuf_addr;
    logic [7:0] buf_wdata, dout;
    logic       s_dbuf_we, s_wbuf_we, s_core_start, s_flag, s_busy, s_err_ovf, s_err_busy;
    logic [4:0] s_dbuf_addr;
    logic [2:0] s_wbuf_addr;
    logic [7:0] s_wdata, s_dout;

    conv_load_ctrl u_dut (
        .clk(clk), .rst(rst), .mode(mode), .din(din), .ram_en(ram_en), .keep_wgt(keep_wgt),
        .dbuf_we(dbuf_we), .dbuf_addr(dbuf_addr), .wbuf_we(wbuf_we), .wbuf_addr(wbuf_addr),
        .buf_wdata(buf_wdata), .core_start(core_start), .core_done(core_done),
        .core_dout(core_dout), .dout(dout), .out_data_flag(out_data_flag), .busy(busy),
        .err_ovf(err_ovf), .err_busy(err_busy)
    );

    conv_load_ctrl #(.IMG_W(4), .IMG_H(4), .IN_CH(2), .K(2), .KC(2), .OUT_CH(1)) u_small (
        .clk(clk), .rst(rst), .mode(mode), .din(din), .ram_en(ram_en_s), .keep_wgt(keep_wgt),
        .dbuf_we(s_dbuf_we), .dbuf_addr(s_dbuf_addr), .wbuf_we(s_wbuf_we), .wbuf_addr(s_wbuf_addr),
        .buf_wdata(s_wdata), .core_start(s_core_start), .core_done(core_done),
        .core_dout(core_dout), .dout(s_dout), .out_data_flag(s_flag), .busy(s_busy),
        .err_ovf(s_err_ovf), .err_busy(s_err_busy)
    );

    always #5 clk = ~clk;

    int          vecs = 0, errs = 0, md = 0, mw = 0, starts = 0, s0 = 0;
    bit          mbusy = 0, ovf_m = 0, busy_m = 0;
    logic [17:0] exp_w[$];
    logic [7:0]  exp_r[$];
    logic        c_start = 0, c_busy = 0, c_flag = 0, prev_flag = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vecs++;
        assert (obs === exp) else begin
            errs++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        logic [17:0] rec;
        @(negedge clk);
        prev_flag = c_flag;
        c_start   = core_start;
        c_busy    = busy;
        c_flag    = out_data_flag;
        if (core_start) starts++;
        if (dbuf_we || wbuf_we) begin
            rec = {dbuf_we, wbuf_we, dbuf_we ? 8'(dbuf_addr) : 8'(wbuf_addr), buf_wdata};
            chk("write_expected", 32'(exp_w.size() != 0), 1);
            if (exp_w.size() != 0) chk("write", 32'(rec), 32'(exp_w.pop_front()));
        end
        if (out_data_flag) begin
            chk("result_expected", 32'(exp_r.size() != 0), 1);
            if (exp_r.size() != 0) chk("dout", dout, 32'(exp_r.pop_front()));
            chk("flag_width", prev_flag, 0);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic m, input logic [7:0] d);
        bit full;
        full = m ? (mw >= WN) : (md >= DN);
        mode = m; din = d; ram_en = 1;
        if (mbusy) busy_m = 1;
        else if (full) ovf_m = 1;
        else begin
            exp_w.push_back({~m, m, m ? 8'(mw) : 8'(md), d});
            if (m) mw++; else md++;
        end
        tick();
        ram_en = 0;
    endtask

    task automatic expect_start();
        tick(); chk("start_pre", c_start, 0);
        tick(); chk("start_pulse", c_start, 1); chk("busy_rise", c_busy, 1);
        tick(); chk("start_one_cycle", c_start, 0);
        mbusy = 1;
    endtask

    task automatic load_frame(input int seed, input bit wfirst, input bit gaps, input bit sw);
        if (sw && wfirst) for (int i = 0; i < WN; i++) send(1, 8'(i * 5 + seed + 100));
        for (int i = 0; i < DN; i++) begin
            send(0, 8'(i * 3 + seed));
            if (gaps && i != DN - 1) tick();
        end
        if (sw && !wfirst) for (int i = 0; i < WN; i++) send(1, 8'(i * 5 + seed + 100));
        expect_start();
    endtask

    task automatic finish(input logic [7:0] val, input bit keep, input bit collide);
        tick();
        core_done = 1; core_dout = val; keep_wgt = keep;
        exp_r.push_back(val);
        if (collide) begin
            ram_en = 1; mode = 0; din = 8'hEE; busy_m = 1;
        end
        tick();
        core_done = 0; ram_en = 0;
        md = 0; mbusy = 0;
        if (!keep) mw = 0;
        tick();
        chk("busy_fall", c_busy, 0);
        chk("flag_pulse", c_flag, 1);
        chk("result_drained", exp_r.size(), 0);
        chk("writes_drained", exp_w.size(), 0);
    endtask

    task automatic chk_err();
        chk("err_ovf", err_ovf, ovf_m);
        chk("err_busy", err_busy, busy_m);
    endtask

    task automatic do_rst();
        rst = 1;
        tick();
        rst = 0;
        md = 0; mw = 0; mbusy = 0; ovf_m = 0; busy_m = 0;
        tick();
        chk("rst_flags", {dbuf_we, wbuf_we, core_start, out_data_flag, busy, err_ovf, err_busy}, 0);
        chk("rst_dbuf_addr", dbuf_addr, 0);
        chk("rst_wbuf_addr", wbuf_addr, 0);
        chk("rst_wdata", buf_wdata, 0);
        chk("rst_dout", dout, 0);
        chk("rst_pending_writes", exp_w.size(), 0);
    endtask

    initial begin
        tick();
        do_rst();
        // image then weights back-to-back
        load_frame(1, 0, 0, 1);
        finish(8'h5A, 0, 0);
        chk_err();
        // weights first, gapped image, bytes during WAIT and at the done edge
        load_frame(9, 1, 1, 1);
        send(0, 8'h77);
        send(1, 8'h78);
        chk_err();
        finish(8'hA7, 0, 1);
        chk_err();
        // weight reuse over three frames
        do_rst();
        load_frame(20, 0, 0, 1);
        finish(8'h11, 1, 0);
        load_frame(30, 0, 0, 0);
        finish(8'h22, 1, 0);
        load_frame(40, 0, 0, 0);
        finish(8'h33, 0, 0);
        // core_done outside WAIT is ignored
        core_done = 1; core_dout = 8'hCC;
        tick();
        core_done = 0;
        tick();
        chk("stray_done_flag", c_flag, 0);
        chk("stray_done_dout", dout, 8'h33);
        // image overflow
        do_rst();
        for (int i = 0; i < DN + 1; i++) send(0, 8'(i + 7));
        tick();
        chk_err();
        for (int i = 0; i < WN; i++) send(1, 8'(i + 50));
        expect_start();
        finish(8'h44, 0, 0);
        chk_err();
        // reset mid-load, then full reload with a single start
        do_rst();
        for (int i = 0; i < 30; i++) send(0, 8'(i * 11));
        do_rst();
        s0 = starts;
        load_frame(55, 0, 0, 1);
        finish(8'h66, 0, 0);
        chk("single_start", starts - s0, 1);
        // reset during WAIT drops a coincident core_done
        load_frame(60, 1, 0, 1);
        rst = 1; core_done = 1; core_dout = 8'h99;
        tick();
        rst = 0; core_done = 0;
        md = 0; mw = 0; mbusy = 0;
        tick();
        chk("rst_wait_flag", c_flag, 0);
        chk("rst_wait_busy", c_busy, 0);
        chk("rst_wait_dout", dout, 0);
        // small geometry: 32 image bytes and 8 weights
        do_rst();
        for (int i = 0; i < 32; i++) begin
            mode = 0; din = 8'(i + 1); ram_en_s = 1;
            tick();
            ram_en_s = 0;
        end
        chk("small_last_img_we", s_dbuf_we, 1);
        chk("small_last_img_addr", s_dbuf_addr, 31);
        tick();
        chk("small_no_start_img", {s_core_start, s_busy}, 0);
        for (int i = 0; i < 8; i++) begin
            mode = 1; din = 8'(i + 200); ram_en_s = 1;
            tick();
            ram_en_s = 0;
        end
        chk("small_last_wgt", {s_wbuf_we, s_wbuf_addr, s_wdata}, {1'b1, 3'd7, 8'd207});
        chk("small_start_pre", s_core_start, 0);
        tick();
        chk("small_start", s_core_start, 1);
        tick();
        chk("small_start_one", {s_core_start, s_busy}, 2'b01);
        tick();
        chk("final_writes_drained", exp_w.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end
endmodule
